// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode/funct constants, ALU/mux codes, output bundle.
package mips_ctrl_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // What kind of ALU operation a state wants; the decoder turns it into alu_ctrl.
   typedef enum logic [1:0] {
      ALU_CLS_ADD   = 2'd0,
      ALU_CLS_SUB   = 2'd1,
      ALU_CLS_FUNCT = 2'd2
   } alu_cls_e;

   // Every datapath control the FSM drives, bundled so reset can blank it in one place.
   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctrl_out_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: control/status bundle between the multi-cycle controller and the MIPS datapath.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory; strobes are held until it is seen.
// Modports: master = controller (drives enables/selects), slave = datapath (drives IR fields, zero, mem_ready).
interface mips_multicycle_ctrl_if;
   import mips_ctrl_pkg::*;

   // datapath -> controller
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;
   logic               mem_ready;

   // controller -> datapath
   logic               pc_en;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [2:0]         alu_ctrl;
   logic [1:0]         pc_src;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_op, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_op, state
   );

endinterface

// File: rtl/mips_alu_decoder.sv
// Purpose: map the FSM's ALU operation class plus R-type funct to an alu_ctrl code.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_cls (in), funct (in) -> alu_ctrl (out), funct_bad (out, only in funct class).
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  alu_cls_e   alu_cls,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_bad
);

   always_comb begin
      alu_ctrl  = ALU_ADD;
      funct_bad = 1'b0;
      case (alu_cls)
         ALU_CLS_SUB: alu_ctrl = ALU_SUB;
         ALU_CLS_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               // Unknown funct keeps the harmless add and is flagged to the FSM.
               default: funct_bad = 1'b1;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: Moore FSM sequencing the shared MIPS datapath through fetch/decode/execute/mem/write-back.
// Latency: outputs decode from the current state in the same cycle; one state per clock.
// Backpressure: FETCH/MEMRD/MEMWR hold their memory strobes and stay put until mem_ready.
// Ports: clk, rst_n (sync, active-low), bus (master modport: IR fields, zero, mem_ready in; all enables/selects, illegal_op, state out).
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   mips_multicycle_ctrl_if.master bus
);

   state_e    state_q;
   state_e    state_d;
   alu_cls_e  alu_cls;
   logic [2:0] dec_alu_ctrl;
   logic       dec_funct_bad;
   ctrl_out_t  ctl;
   ctrl_out_t  ctl_o;

   // ALU class depends on state alone, kept apart from the main decode so the
   // decoder result can feed next-state logic without a combinational loop.
   always_comb begin
      alu_cls = ALU_CLS_ADD;
      case (state_q)
         S_EXEC:   alu_cls = ALU_CLS_FUNCT;
         S_BRANCH: alu_cls = ALU_CLS_SUB;
         default:  alu_cls = ALU_CLS_ADD;
      endcase
   end

   mips_alu_decoder u_alu_dec (
      .alu_cls   (alu_cls),
      .funct     (bus.funct),
      .alu_ctrl  (dec_alu_ctrl),
      .funct_bad (dec_funct_bad)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      ctl          = '0;
      ctl.alu_ctrl = dec_alu_ctrl;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            ctl.pc_src    = PCSRC_ALU;
            // IR load and PC+4 commit only on the cycle memory delivers.
            if (bus.mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_en    = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculative branch target into ALUOut.
            ctl.alu_src_b = SRCB_IMM_SH;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  ctl.illegal_op = 1'b1;
                  state_d        = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            // IR is frozen after FETCH, so opcode still names lw or sw here.
            state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEMWR: begin
            ctl.mem_write = 1'b1;
            ctl.iord      = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_B;
            if (dec_funct_bad) begin
               ctl.illegal_op = 1'b1;
               state_d        = S_FETCH;
            end else begin
               state_d = S_ALUWB;
            end
         end
         S_ALUWB: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = 1'b1;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_B;
            ctl.pc_src    = PCSRC_ALUOUT;
            ctl.pc_en     = bus.zero;
            state_d       = S_FETCH;
         end
         S_ADDIEX: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = SRCB_IMM;
            state_d       = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctl.reg_write = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            ctl.pc_src = PCSRC_JUMP;
            ctl.pc_en  = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // During reset every control is blanked so nothing in flight can write.
   assign ctl_o = rst_n ? ctl : '0;

   assign bus.pc_en      = ctl_o.pc_en;
   assign bus.iord       = ctl_o.iord;
   assign bus.mem_read   = ctl_o.mem_read;
   assign bus.mem_write  = ctl_o.mem_write;
   assign bus.ir_write   = ctl_o.ir_write;
   assign bus.reg_dst    = ctl_o.reg_dst;
   assign bus.mem_to_reg = ctl_o.mem_to_reg;
   assign bus.reg_write  = ctl_o.reg_write;
   assign bus.alu_src_a  = ctl_o.alu_src_a;
   assign bus.alu_src_b  = ctl_o.alu_src_b;
   assign bus.alu_ctrl   = ctl_o.alu_ctrl;
   assign bus.pc_src     = ctl_o.pc_src;
   assign bus.illegal_op = ctl_o.illegal_op;
   assign bus.state      = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: self-checking bench for mips_multicycle_ctrl.
// Latency: n/a.
// Backpressure: bench drives mem_ready stalls.
module tb_mips_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_src;
      logic       illegal_op;
      logic [3:0] state;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         cycles;
      int         writes;
      int         pc_loads;
      int         illegals;
      string      name;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   bit mr_plan[$];
   int zero_force = -1;

   function automatic obs_t sample();
      obs_t o;
      o.pc_en      = bus.pc_en;
      o.iord       = bus.iord;
      o.mem_read   = bus.mem_read;
      o.mem_write  = bus.mem_write;
      o.ir_write   = bus.ir_write;
      o.reg_dst    = bus.reg_dst;
      o.mem_to_reg = bus.mem_to_reg;
      o.reg_write  = bus.reg_write;
      o.alu_src_a  = bus.alu_src_a;
      o.alu_src_b  = bus.alu_src_b;
      o.alu_ctrl   = bus.alu_ctrl;
      o.pc_src     = bus.pc_src;
      o.illegal_op = bus.illegal_op;
      o.state      = bus.state;
      return o;
   endfunction

   function automatic obs_t base(input logic [3:0] s);
      obs_t o;
      o          = '0;
      o.alu_ctrl = 3'b010;
      o.state    = s;
      return o;
   endfunction

   task automatic chk(input obs_t e, input string nm);
      obs_t a;
      a = sample();
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
      end
   endtask

   task automatic chk_int(input int act, input int exp, input string nm);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Inputs are applied just after the falling edge; outputs are sampled 1 time unit later.
   task automatic apply(input bit mr);
      bit z;
      z = (zero_force >= 0) ? zero_force[0] : 1'($urandom_range(0, 1));
      bus.mem_ready = mr;
      bus.zero      = z;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit next_mr();
      if (mr_plan.size() > 0) return mr_plan.pop_front();
      return ($urandom_range(0, 3) != 0);
   endfunction

   // Reference ALU decode for R-type instructions.
   task automatic ref_rtype(input logic [5:0] fn, output logic [2:0] c, output bit ok);
      ok = 1'b1;
      case (fn)
         6'b100000: c = 3'b010;
         6'b100010: c = 3'b110;
         6'b100100: c = 3'b000;
         6'b100101: c = 3'b001;
         6'b101010: c = 3'b111;
         default: begin c = 3'b010; ok = 1'b0; end
      endcase
   endtask

   // Instruction-level reference: walks the cycles one instruction must take and
   // what each of those cycles must show, starting from a fetch.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
      obs_t e;
      bit mr;
      bit known;
      bit ok;
      logic [2:0] c;
      bus.opcode = op;
      bus.funct  = fn;
      do begin
         mr = next_mr();
         apply(mr);
         e = base(S_FETCH); e.mem_read = 1; e.alu_src_b = 2'b01;
         if (mr) begin e.ir_write = 1; e.pc_en = 1; end
         chk(e, "fetch");
         tick();
      end while (!mr);
      known = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
              (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
      apply(1'($urandom_range(0, 1)));
      e = base(S_DECODE); e.alu_src_b = 2'b11; e.illegal_op = !known;
      chk(e, "decode");
      tick();
      if (!known) return;
      if (op == 6'b100011 || op == 6'b101011) begin
         apply(1'($urandom_range(0, 1)));
         e = base(S_MEMADR); e.alu_src_a = 1; e.alu_src_b = 2'b10;
         chk(e, "memadr");
         tick();
         do begin
            mr = next_mr();
            apply(mr);
            if (op == 6'b100011) begin
               e = base(S_MEMRD); e.mem_read = 1;
            end else begin
               e = base(S_MEMWR); e.mem_write = 1;
            end
            e.iord = 1;
            chk(e, "memaccess");
            tick();
         end while (!mr);
         if (op == 6'b100011) begin
            apply(1'($urandom_range(0, 1)));
            e = base(S_MEMWB); e.reg_write = 1; e.mem_to_reg = 1;
            chk(e, "memwb");
            tick();
         end
      end else if (op == 6'b000000) begin
         ref_rtype(fn, c, ok);
         apply(1'($urandom_range(0, 1)));
         e = base(S_EXEC); e.alu_src_a = 1; e.alu_ctrl = c; e.illegal_op = !ok;
         chk(e, "exec");
         tick();
         if (ok) begin
            apply(1'($urandom_range(0, 1)));
            e = base(S_ALUWB); e.reg_write = 1; e.reg_dst = 1;
            chk(e, "aluwb");
            tick();
         end
      end else if (op == 6'b000100) begin
         apply(1'($urandom_range(0, 1)));
         e = base(S_BRANCH); e.alu_src_a = 1; e.alu_ctrl = 3'b110;
         e.pc_src = 2'b01; e.pc_en = bus.zero;
         chk(e, "branch");
         tick();
      end else if (op == 6'b001000) begin
         apply(1'($urandom_range(0, 1)));
         e = base(S_ADDIEX); e.alu_src_a = 1; e.alu_src_b = 2'b10;
         chk(e, "addiex");
         tick();
         apply(1'($urandom_range(0, 1)));
         e = base(S_ADDIWB); e.reg_write = 1;
         chk(e, "addiwb");
         tick();
      end else begin
         apply(1'($urandom_range(0, 1)));
         e = base(S_JUMP); e.pc_src = 2'b10; e.pc_en = 1;
         chk(e, "jump");
         tick();
      end
   endtask

   // Zero-wait run of one instruction from FETCH, tallying cycles and key strobes.
   task automatic run_count(input vec_t v);
      obs_t s;
      int cyc = 0, rw = 0, pe = 0, il = 0;
      bit done = 0;
      bus.opcode = v.op;
      bus.funct  = v.fn;
      while (!done && cyc < 20) begin
         bus.mem_ready = 1'b1;
         bus.zero      = v.z;
         #1;
         s = sample();
         rw += int'(s.reg_write);
         pe += int'(s.pc_en);
         il += int'(s.illegal_op);
         tick();
         cyc++;
         done = (bus.state == S_FETCH);
      end
      chk_int(cyc, v.cycles, {v.name, "_cycles"});
      chk_int(rw,  v.writes, {v.name, "_reg_write"});
      chk_int(pe,  v.pc_loads, {v.name, "_pc_en"});
      chk_int(il,  v.illegals, {v.name, "_illegal"});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[11];
      obs_t e;
      logic [5:0] ops[7];
      logic [5:0] fns[6];

      vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 1, 1, 0, "lw"};
      vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 0, 1, 0, "sw"};
      vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 1, 1, 0, "add"};
      vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 1, 1, 0, "sub"};
      vecs[4]  = '{6'b000000, 6'b101010, 1'b0, 4, 1, 1, 0, "slt"};
      vecs[5]  = '{6'b000000, 6'b000111, 1'b0, 3, 0, 1, 1, "rbad"};
      vecs[6]  = '{6'b000100, 6'b000000, 1'b1, 3, 0, 2, 0, "beq_t"};
      vecs[7]  = '{6'b000100, 6'b000000, 1'b0, 3, 0, 1, 0, "beq_nt"};
      vecs[8]  = '{6'b001000, 6'b000000, 1'b0, 4, 1, 1, 0, "addi"};
      vecs[9]  = '{6'b000010, 6'b000000, 1'b0, 3, 0, 2, 0, "j"};
      vecs[10] = '{6'b111111, 6'b000000, 1'b0, 2, 0, 1, 1, "badop"};

      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);

      // Reset held with random inputs: everything blank, state reads FETCH.
      for (int i = 0; i < 3; i++) begin
         bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
         bus.zero = 1'($urandom); bus.mem_ready = 1'($urandom);
         #1;
         chk('0, "reset_hold");
         tick();
      end
      rst_n = 1'b1;
      apply(1'b0);
      e = base(S_FETCH); e.mem_read = 1; e.alu_src_b = 2'b01;
      chk(e, "reset_release_fetch");
      tick();

      // Instruction-level CPI / strobe tallies with zero-wait memory.
      foreach (vecs[i]) run_count(vecs[i]);

      // Hand sequences for the multi-cycle corners.
      mr_plan = '{1, 1};
      run_instr(6'b100011, 6'b000000);                 // lw, no stalls
      mr_plan = '{1, 0, 0, 0, 1};
      run_instr(6'b101011, 6'b000000);                 // sw, 3 stalls in MEMWR
      mr_plan = '{0, 0, 1};
      run_instr(6'b000000, 6'b100010);                 // sub after fetch stalls
      run_instr(6'b000000, 6'b000111);                 // bad funct
      zero_force = 1; run_instr(6'b000100, 6'b000000); // beq taken
      zero_force = 0; run_instr(6'b000100, 6'b000000); // beq not taken
      zero_force = -1;
      run_instr(6'b000010, 6'b000000);                 // j

      // Reset while MEMRD is waiting: strobe drops, no write-back follows.
      bus.opcode = 6'b100011; bus.funct = '0;
      apply(1'b1); tick();          // FETCH
      apply(1'b0); tick();          // DECODE
      apply(1'b0); tick();          // MEMADR
      apply(1'b0);
      e = base(S_MEMRD); e.mem_read = 1; e.iord = 1;
      chk(e, "memrd_wait");
      tick();
      rst_n = 1'b0;
      apply(1'b1);
      chk('0, "memrd_reset_forced");
      tick();
      rst_n = 1'b1;
      apply(1'b0);
      e = base(S_FETCH); e.mem_read = 1; e.alu_src_b = 2'b01;
      chk(e, "memrd_reset_to_fetch");
      tick();

      // Randomized instruction stream against the reference.
      for (int n = 0; n < 150; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr(op, fn);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control unit for the MIPS core: a Moore-style state machine that sequences the shared datapath (single memory port, single ALU, register file, PC/IR) through fetch, decode, execute, memory and write-back per instruction. It sits beside the datapath inside `MIPS`, takes the IR opcode/funct fields, the ALU zero flag and a memory ready handshake, and drives every datapath enable and mux select. It also owns the ALU operation decode.

## Interface
- No parameters; encodings are fixed in the shared package.
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_en  out  1  PC register load (pc_write | (branch & zero))
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read / mem_write  out  1 each  memory strobes, held until mem_ready
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 0=rt, 1=rd
- mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_ctrl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  4  current state, debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. Stay while mem_ready=0 (ir_write, pc_en low). On mem_ready=1: ir_write=1, pc_en=1, go DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next by opcode: 100011 lw / 101011 sw -> MEMADR; 000000 R -> EXEC; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP; other -> FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1; wait for mem_ready, then MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_write=1, iord=1; wait for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Unsupported funct: illegal_op=1, go FETCH, no write-back. Else ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH.
- Any output not listed for a state is 0; alu_ctrl defaults to add.

## Timing
- State register updates on rising clk; outputs decode from state (plus mem_ready, zero, funct as listed), no added latency.
- Reset: rst_n low at a rising edge -> state=FETCH next cycle. While rst_n is low, all outputs are forced to 0 and state reads FETCH. Reset mid-instruction abandons it; no partial write occurs after the reset edge.
- Zero-wait memory CPI: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle adds one cycle in FETCH/MEMRD/MEMWR.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR. Strobes stay asserted and stable until the completing cycle.
- illegal_op is high only in the DECODE or EXEC cycle that detects it.

## Structure
- Package `mips_ctrl_pkg` holds: the state enum (4-bit), opcode and funct constants, alu_ctrl codes, alu_src_b and pc_src codes.
- Sub-module `mips_alu_decoder` is combinational: state class + funct -> alu_ctrl, illegal funct flag. The FSM lives in `mips_multicycle_ctrl`.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs -> all outputs 0, state=FETCH. Release -> mem_read=1 in the first cycle.
- lw (opcode 100011), mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1 in cycle 5 only.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH; reg_write never asserted.
- R-type sub (funct 100010) -> alu_ctrl=110 in EXEC, then reg_write=1 with reg_dst=1. R-type funct 000111 -> illegal_op pulse and return to FETCH, no reg_write.
- beq with zero=1 -> pc_en=1, pc_src=01 in cycle 3. With zero=0 -> pc_en=0. j -> pc_en=1, pc_src=10.
- Reset asserted in MEMRD while waiting for mem_ready -> next cycle state=FETCH, mem_read drops during reset, no MEMWB write.
